// File: rtl/sram_arb_pkg.sv
// Shared types, default timing and helpers for the two-master asynchronous SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W   = 18;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_WR_CYC   = 3;
    localparam int unsigned DEF_RD_CYC   = 3;
    localparam int unsigned DEF_TURN_CYC = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Active-low lane strobes {UB_n, LB_n} from active-high byte enables {be[1], be[0]}
    function automatic logic [1:0] be_to_ublb(input logic [1:0] be);
        return ~be;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Single-word request/response channel between one master and the SRAM arbiter.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, we, addr, wdata, be,
        input  ready, rsp_valid, rdata
    );

    modport slave (
        input  valid, we, addr, wdata, be,
        output ready, rsp_valid, rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last accepted master.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt_c,
    output logic       o_idx_c
);
    logic r_last;

    // On a tie the master not granted last wins
    always_comb begin
        o_gnt_c = 2'b00;
        o_idx_c = 1'b0;
        case (i_req)
            2'b01: begin
                o_gnt_c = 2'b01;
                o_idx_c = 1'b0;
            end
            2'b10: begin
                o_gnt_c = 2'b10;
                o_idx_c = 1'b1;
            end
            2'b11: begin
                o_gnt_c = r_last ? 2'b01 : 2'b10;
                o_idx_c = ~r_last;
            end
            default: ;
        endcase
    end

    // Reset value 1 makes m0 the first winner
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= o_idx_c;
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and registered strobe sequencer for a 16-bit asynchronous SRAM.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WR_CYC   = DEF_WR_CYC,
    parameter int unsigned RD_CYC   = DEF_RD_CYC,
    parameter int unsigned TURN_CYC = DEF_TURN_CYC
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    sram_arbiter_if.slave     m0,
    sram_arbiter_if.slave     m1,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE,
    output logic              SRAM_OE,
    output logic              SRAM_WE,
    output logic              SRAM_UB,
    output logic              SRAM_LB
);
    localparam int unsigned BYTE_W = DATA_W / 2;
    localparam int unsigned CNT_W  = $clog2(max3(WR_CYC, RD_CYC, TURN_CYC)) + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [1:0]         r_be;
    logic               r_gidx;

    logic [1:0]         w_req;
    logic [1:0]         w_gnt;
    logic               w_widx;
    logic               w_idle;
    logic               w_accept;

    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [1:0]         w_sel_be;

    logic               r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
    logic               w_ce_n, w_oe_n, w_we_n, w_ub_n, w_lb_n;
    logic [ADDR_W-1:0]  r_pin_addr, w_pin_addr;
    logic               r_dq_oe, w_dq_oe;
    logic [DATA_W-1:0]  r_dq_out, w_dq_out;

    logic               w_rd_done;
    logic [DATA_W-1:0]  w_rd_data;
    logic               r_rsp0, r_rsp1;
    logic [DATA_W-1:0]  r_rdata0, r_rdata1;

    assign w_req    = {m1.valid, m0.valid};
    assign w_idle   = (r_state == ST_IDLE) && !sys_rst;
    assign w_accept = w_idle && (|w_req);

    rr_arb2 u_rr_arb2 (
        .i_clk    (sys_clk),
        .i_rst    (sys_rst),
        .i_req    (w_req),
        .i_accept (w_accept),
        .o_gnt_c  (w_gnt),
        .o_idx_c  (w_widx)
    );

    assign m0.ready = w_idle && w_gnt[0];
    assign m1.ready = w_idle && w_gnt[1];

    assign w_sel_we    = w_widx ? m1.we    : m0.we;
    assign w_sel_addr  = w_widx ? m1.addr  : m0.addr;
    assign w_sel_wdata = w_widx ? m1.wdata : m0.wdata;
    assign w_sel_be    = w_widx ? m1.be    : m0.be;

    // State register and wait counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_W'(1);
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: each timed state exits when the counter reaches 1
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_SETUP;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            ST_SETUP: begin
                w_next_state = r_we ? ST_WRITE : ST_READ;
                w_cnt_next   = r_we ? CNT_W'(WR_CYC) : CNT_W'(RD_CYC);
            end
            ST_WRITE, ST_READ: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_HOLD;
                    w_cnt_next   = CNT_W'(TURN_CYC);
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = CNT_W'(1);
            end
        endcase
    end

    // Pin values for the state being entered, so the flops present them for that whole state
    always_comb begin
        w_ce_n     = 1'b1;
        w_oe_n     = 1'b1;
        w_we_n     = 1'b1;
        w_ub_n     = 1'b1;
        w_lb_n     = 1'b1;
        w_pin_addr = r_pin_addr;
        w_dq_oe    = 1'b0;
        w_dq_out   = r_dq_out;
        case (w_next_state)
            ST_SETUP: begin
                w_ce_n           = 1'b0;
                {w_ub_n, w_lb_n} = be_to_ublb(w_sel_be);
                w_pin_addr       = w_sel_addr;
                w_dq_oe          = w_sel_we;
                w_dq_out         = w_sel_wdata;
            end
            ST_WRITE: begin
                w_ce_n           = 1'b0;
                w_we_n           = 1'b0;
                {w_ub_n, w_lb_n} = be_to_ublb(r_be);
                w_dq_oe          = 1'b1;
                w_dq_out         = r_wdata;
            end
            ST_READ: begin
                w_ce_n           = 1'b0;
                w_oe_n           = 1'b0;
                {w_ub_n, w_lb_n} = be_to_ublb(r_be);
            end
            ST_HOLD: begin
                w_dq_oe          = (r_state == ST_WRITE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_ub_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_pin_addr <= '0;
            r_dq_oe    <= 1'b0;
            r_dq_out   <= '0;
        end else begin
            r_ce_n     <= w_ce_n;
            r_oe_n     <= w_oe_n;
            r_we_n     <= w_we_n;
            r_ub_n     <= w_ub_n;
            r_lb_n     <= w_lb_n;
            r_pin_addr <= w_pin_addr;
            r_dq_oe    <= w_dq_oe;
            r_dq_out   <= w_dq_out;
        end
    end

    assign SRAM_CE   = r_ce_n;
    assign SRAM_OE   = r_oe_n;
    assign SRAM_WE   = r_we_n;
    assign SRAM_UB   = r_ub_n;
    assign SRAM_LB   = r_lb_n;
    assign SRAM_ADDR = r_pin_addr;
    assign SRAM_DQ   = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};

    // Request capture at acceptance
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= 2'b00;
            r_gidx  <= 1'b0;
        end else if (w_accept) begin
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_be    <= w_sel_be;
            r_gidx  <= w_widx;
        end
    end

    // Sample on the edge that closes the last READ cycle; disabled lanes read as zero
    assign w_rd_done = (r_state == ST_READ) && (r_cnt == CNT_W'(1));
    assign w_rd_data = {r_be[1] ? SRAM_DQ[DATA_W-1:BYTE_W] : BYTE_W'(0),
                        r_be[0] ? SRAM_DQ[BYTE_W-1:0]      : BYTE_W'(0)};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rsp0   <= 1'b0;
            r_rsp1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_rsp0 <= w_rd_done && !r_gidx;
            r_rsp1 <= w_rd_done &&  r_gidx;
            if (w_rd_done && !r_gidx) begin
                r_rdata0 <= w_rd_data;
            end
            if (w_rd_done && r_gidx) begin
                r_rdata1 <= w_rd_data;
            end
        end
    end

    assign m0.rsp_valid = r_rsp0;
    assign m1.rsp_valid = r_rsp1;
    assign m0.rdata     = r_rdata0;
    assign m1.rdata     = r_rdata1;

    // r_addr mirrors the pin address; kept so the captured request is complete
    logic w_unused;
    assign w_unused = ^r_addr;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: default-timing arbiter (A) plus a WR=1/RD=5/TURN=2 instance (B).
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) a0 ();
    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) a1 ();
    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) b0 ();
    sram_arbiter_if #(.ADDR_W(18), .DATA_W(16)) b1 ();

    wire  [15:0] dq_a, dq_b;
    logic [17:0] addr_a, addr_b;
    logic        ce_a, oe_a, we_a, ub_a, lb_a;
    logic        ce_b, oe_b, we_b, ub_b, lb_b;
    logic [15:0] mdl_a, mdl_b;
    logic        prb_en;
    logic [15:0] prb_val;

    // SRAM read model drives while selected with OE low; probe driver tests for high-Z
    assign dq_a = (!ce_a && !oe_a) ? mdl_a : 16'hzzzz;
    assign dq_b = (!ce_b && !oe_b) ? mdl_b : 16'hzzzz;
    assign dq_a = prb_en ? prb_val : 16'hzzzz;
    assign dq_b = prb_en ? prb_val : 16'hzzzz;

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WR_CYC(3), .RD_CYC(3), .TURN_CYC(1)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst), .m0(a0), .m1(a1), .SRAM_DQ(dq_a), .SRAM_ADDR(addr_a),
        .SRAM_CE(ce_a), .SRAM_OE(oe_a), .SRAM_WE(we_a), .SRAM_UB(ub_a), .SRAM_LB(lb_a)
    );

    sram_arbiter #(.ADDR_W(18), .DATA_W(16), .WR_CYC(1), .RD_CYC(5), .TURN_CYC(2)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst), .m0(b0), .m1(b1), .SRAM_DQ(dq_b), .SRAM_ADDR(addr_b),
        .SRAM_CE(ce_b), .SRAM_OE(oe_b), .SRAM_WE(we_b), .SRAM_UB(ub_b), .SRAM_LB(lb_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Undriven bus reads back whatever the probe drives, for both polarities
    task automatic chk_hiz(input string tag, input logic sel_b);
        logic [15:0] r0, r1;
        prb_val = 16'h0000; prb_en = 1'b1; #1;
        r0 = sel_b ? dq_b : dq_a;
        prb_val = 16'hFFFF; #1;
        r1 = sel_b ? dq_b : dq_a;
        prb_en = 1'b0; #1;
        chk(tag, {r0, r1}, 32'h0000_FFFF);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; prb_en = 1'b0; prb_val = '0; mdl_a = '0; mdl_b = '0;
        a0.valid = 1'b1; a0.we = 1'b0; a0.addr = '0; a0.wdata = '0; a0.be = 2'b11;
        a1.valid = 1'b1; a1.we = 1'b0; a1.addr = '0; a1.wdata = '0; a1.be = 2'b11;
        b0.valid = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wdata = '0; b0.be = 2'b11;
        b1.valid = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wdata = '0; b1.be = 2'b11;
        #1;
        chk("rst_ready_pre", {a1.ready, a0.ready}, 2'b00);
        tick(); tick();
        chk("rst_strobes_a", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b11111);
        chk("rst_strobes_b", {ce_b, oe_b, we_b, ub_b, lb_b}, 5'b11111);
        chk("rst_addr", addr_a, 18'h0);
        chk("rst_ready", {a1.ready, a0.ready}, 2'b00);
        chk("rst_rsp", {a1.rsp_valid, a0.rsp_valid}, 2'b00);
        chk("rst_rdata", {a1.rdata, a0.rdata}, 32'h0);
        chk_hiz("rst_dq", 1'b0);
        a0.valid = 1'b0; a1.valid = 1'b0; rst = 1'b0;

        // m0 write A55A to 0x10
        a0.we = 1'b1; a0.addr = 18'h00010; a0.wdata = 16'hA55A; a0.be = 2'b11; a0.valid = 1'b1;
        #1;
        chk("wr_ready", {a1.ready, a0.ready}, 2'b01);
        tick(); a0.valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            chk($sformatf("wr_pins_c%0d", c), {ce_a, oe_a, we_a, ub_a, lb_a},
                {(c <= 4) ? 1'b0 : 1'b1, 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1,
                 (c <= 4) ? 2'b00 : 2'b11});
            chk($sformatf("wr_addr_c%0d", c), addr_a, 18'h00010);
            if (c <= 5) chk($sformatf("wr_dq_c%0d", c), dq_a, 16'hA55A);
            else        chk_hiz($sformatf("wr_dq_c%0d", c), 1'b0);
        end

        // m1 read 0x10, model returns A55A
        a1.we = 1'b0; a1.addr = 18'h00010; a1.be = 2'b11; a1.valid = 1'b1; mdl_a = 16'hA55A;
        #1;
        chk("rd_ready", {a1.ready, a0.ready}, 2'b10);
        tick(); a1.valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) tick();
            chk($sformatf("rd_pins_c%0d", c), {ce_a, oe_a, we_a, ub_a, lb_a},
                {(c <= 4) ? 1'b0 : 1'b1, (c >= 2 && c <= 4) ? 1'b0 : 1'b1, 1'b1,
                 (c <= 4) ? 2'b00 : 2'b11});
            chk($sformatf("rd_rsp_c%0d", c), {a1.rsp_valid, a0.rsp_valid},
                (c == 5) ? 2'b10 : 2'b00);
            if (c >= 5) chk($sformatf("rd_rdata_c%0d", c), {a1.rdata, a0.rdata}, 32'hA55A_0000);
            if (c == 1 || c >= 5) chk_hiz($sformatf("rd_dq_c%0d", c), 1'b0);
        end

        // Both masters valid for 8 accesses: strict alternation, 6 cycles each
        a0.we = 1'b1; a0.addr = 18'h00100; a0.wdata = 16'h1111; a0.be = 2'b11;
        a1.we = 1'b1; a1.addr = 18'h00200; a1.wdata = 16'h2222; a1.be = 2'b11;
        a0.valid = 1'b1; a1.valid = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rr_grant_k%0d", k), {a1.ready, a0.ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk($sformatf("rr_addr_k%0d", k), addr_a, (k % 2 == 0) ? 18'h00100 : 18'h00200);
            tick(); tick(); tick(); tick();
            chk($sformatf("rr_busy_c5_k%0d", k), {a1.ready, a0.ready, ce_a}, 3'b001);
            tick();
        end
        a0.valid = 1'b0; a1.valid = 1'b0;

        // m0 read lower byte only
        a0.we = 1'b0; a0.addr = 18'h00020; a0.be = 2'b01; a0.valid = 1'b1; mdl_a = 16'h1234;
        #1;
        chk("be01_ready", {a1.ready, a0.ready}, 2'b01);
        tick(); a0.valid = 1'b0;
        chk("be01_setup", {ce_a, ub_a, lb_a}, 3'b010);
        chk("be01_addr", addr_a, 18'h00020);
        tick(); tick(); tick();
        chk("be01_read", {ce_a, oe_a, ub_a, lb_a}, 4'b0010);
        tick();
        chk("be01_rsp", {a1.rsp_valid, a0.rsp_valid}, 2'b01);
        chk("be01_rdata", a0.rdata, 16'h0034);
        tick();
        chk("be01_rsp_end", {a1.rsp_valid, a0.rsp_valid}, 2'b00);
        chk("be01_rdata_hold", a0.rdata, 16'h0034);

        // m1 read with no lanes enabled
        a1.we = 1'b0; a1.addr = 18'h00030; a1.be = 2'b00; a1.valid = 1'b1;
        #1;
        chk("be00_ready", {a1.ready, a0.ready}, 2'b10);
        tick(); a1.valid = 1'b0;
        chk("be00_setup", {ce_a, oe_a, ub_a, lb_a}, 4'b0111);
        tick();
        chk("be00_read", {ce_a, oe_a, ub_a, lb_a}, 4'b0011);
        tick(); tick(); tick();
        chk("be00_rsp", {a1.rsp_valid, a0.rsp_valid}, 2'b10);
        chk("be00_rdata", a1.rdata, 16'h0000);
        tick();

        // Reset during second WRITE cycle aborts the access
        a0.we = 1'b1; a0.addr = 18'h00040; a0.wdata = 16'h5AA5; a0.be = 2'b11; a0.valid = 1'b1;
        #1;
        chk("abort_ready", {a1.ready, a0.ready}, 2'b01);
        tick(); a0.valid = 1'b0;
        tick();
        chk("abort_wr1", we_a, 1'b0);
        tick();
        chk("abort_wr2", {we_a, dq_a}, {1'b0, 16'h5AA5});
        rst = 1'b1; a0.valid = 1'b1; a1.valid = 1'b1;
        #1;
        chk("abort_ready_in_rst", {a1.ready, a0.ready}, 2'b00);
        tick();
        chk("abort_strobes", {ce_a, oe_a, we_a, ub_a, lb_a}, 5'b11111);
        chk("abort_ready_after", {a1.ready, a0.ready}, 2'b00);
        chk("abort_rsp", {a1.rsp_valid, a0.rsp_valid}, 2'b00);
        chk_hiz("abort_dq", 1'b0);
        rst = 1'b0;
        #1;
        chk("abort_m0_first", {a1.ready, a0.ready}, 2'b01);
        a0.valid = 1'b0; a1.valid = 1'b0;
        tick();
        chk("abort_idle", {ce_a, oe_a, we_a, a1.rsp_valid, a0.rsp_valid}, 5'b11100);

        // Instance B: WR_CYC=1, RD_CYC=5, TURN_CYC=2
        b0.we = 1'b1; b0.addr = 18'h00055; b0.wdata = 16'hC3C3; b0.be = 2'b11; b0.valid = 1'b1;
        #1;
        chk("b_wr_ready", b0.ready, 1'b1);
        tick(); b0.valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            chk($sformatf("b_wr_pins_c%0d", c), {ce_b, oe_b, we_b},
                {(c <= 2) ? 1'b0 : 1'b1, 1'b1, (c == 2) ? 1'b0 : 1'b1});
            if (c <= 3) chk($sformatf("b_wr_dq_c%0d", c), dq_b, 16'hC3C3);
            else        chk_hiz($sformatf("b_wr_dq_c%0d", c), 1'b1);
        end
        b0.we = 1'b0; b0.valid = 1'b1; mdl_b = 16'h0F0F;
        #1;
        chk("b_rd_ready", b0.ready, 1'b1);
        tick(); b0.valid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) tick();
            if (c == 8) begin
                b0.valid = 1'b1;
                #1;
            end
            chk($sformatf("b_rd_oe_c%0d", c), {ce_b, oe_b},
                {(c <= 6) ? 1'b0 : 1'b1, (c >= 2 && c <= 6) ? 1'b0 : 1'b1});
            chk($sformatf("b_rd_rsp_c%0d", c), b0.rsp_valid, (c == 7) ? 1'b1 : 1'b0);
            if (c >= 7) chk($sformatf("b_rd_rdata_c%0d", c), b0.rdata, 16'h0F0F);
            if (c >= 8) chk($sformatf("b_rd_ready_c%0d", c), b0.ready, (c == 9) ? 1'b1 : 1'b0);
        end
        b0.valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and timing sequencer for the board's external 256K×16 asynchronous SRAM. It accepts single-word read and write requests from two masters, for example the AD capture path and the DA playback path. It grants the SRAM to the masters in round-robin order and generates registered CE/OE/WE/UB/LB, address and bidirectional data timing from `sys_clk`. It sits between the system logic and the SRAM pins and replaces ad-hoc counter-driven SRAM strobing.

## Interface
Parameters:
- `ADDR_W`, 18: SRAM address width.
- `DATA_W`, 16: SRAM data width; must be 16 (two byte lanes).
- `WR_CYC`, 3: number of cycles WE is held low; minimum 1.
- `RD_CYC`, 3: number of cycles OE is held low before data is sampled; minimum 1.
- `TURN_CYC`, 1: bus-turnaround/hold cycles after each access; minimum 1.

Ports:
- `sys_clk` in 1: single clock, rising edge.
- `sys_rst` in 1: reset, synchronous and active-high.
- `mN_valid` in 1 (N=0,1): request valid; held stable until accepted.
- `mN_ready` out 1: request accepted when valid && ready.
- `mN_we` in 1: 1 = write, 0 = read.
- `mN_addr` in ADDR_W: word address.
- `mN_wdata` in DATA_W: write data.
- `mN_be` in 2: byte enables; bit1 = upper byte, bit0 = lower byte.
- `mN_rsp_valid` out 1: one-cycle pulse, read data valid.
- `mN_rdata` out DATA_W: read data, held until the next read response to that master.
- `SRAM_DQ` inout DATA_W: data bus.
- `SRAM_ADDR` out ADDR_W: address.
- `SRAM_CE`, `SRAM_OE`, `SRAM_WE`, `SRAM_UB`, `SRAM_LB` out 1 each: active-low strobes.

## Operation
- FSM states: IDLE → SETUP → WRITE or READ → HOLD → IDLE.
- IDLE:
  - `mN_ready` is combinational: high only in IDLE, and only for the arbitration winner.
  - On acceptance, latch we, addr, wdata, be and the grant index, then go to SETUP.
- Arbitration is round-robin with a pointer to the last-granted master.
  - When both masters are valid, the master not granted last wins.
  - The pointer updates only on acceptance.
  - After reset, m0 has priority.
- SETUP (1 cycle):
  - ADDR driven; CE=0; UB=~be[1]; LB=~be[0]; OE=WE=1.
  - For a write, DQ is driven with wdata.
- WRITE (WR_CYC cycles): WE=0, CE=0, DQ driven.
- READ (RD_CYC cycles):
  - OE=0, CE=0, DQ high-Z.
  - DQ is sampled at the clock edge that ends the last READ cycle.
  - Byte lanes with be=0 read as 8'h00.
- HOLD (TURN_CYC cycles):
  - CE=OE=WE=UB=LB=1; ADDR unchanged.
  - After a write, DQ stays driven for the first HOLD cycle only, then goes high-Z.
  - After a read, the granted master's `mN_rsp_valid` pulses in the first HOLD cycle.
- be=2'b00: the full cycle still runs with UB=LB=1 (no array effect); a read still returns rdata=0 with rsp_valid.
- Counters: one wait counter, width clog2(max(WR_CYC,RD_CYC,TURN_CYC))+1. It loads at state entry and decrements; the state exits when the counter reaches 1.
- ADDR does not wrap or increment; it is exactly the requester's address.

## Timing
- Reset values (registered):
  - State = IDLE.
  - SRAM_CE/OE/WE/UB/LB = 1, SRAM_ADDR = 0, DQ high-Z.
  - `mN_rsp_valid` = 0, `mN_rdata` = 0, RR pointer favours m0.
- `mN_ready` is 0 whenever not in IDLE, including during the reset cycle.
- Reset asserted mid-access aborts the access. At the next edge all strobes are 1, DQ is high-Z, and no response is issued.
- All SRAM pin outputs come directly from flops, with no combinational path from `mN_*` to the pins.
- Cycle map with acceptance at edge E0:
  - SETUP is cycle 1.
  - Access is cycles 2 .. 1+X, where X = WR_CYC or RD_CYC.
  - HOLD is cycles 2+X .. 1+X+TURN_CYC.
  - IDLE is cycle 2+X+TURN_CYC; a new acceptance is possible then.
- Read latency with default parameters: rsp_valid in cycle 5 after acceptance.
- Throughput with default parameters: one access per 6 cycles.
- A request arriving during a non-IDLE state waits; it is never dropped.
- Simultaneous requests are resolved by the RR pointer with no starvation. Each master waits at most one access of the other master.

## Structure
- Package `sram_arb_pkg`:
  - State enum (IDLE, SETUP, WRITE, READ, HOLD).
  - Byte-enable-to-UB/LB helper.
  - Default timing localparams.
- Sub-module `rr_arb2`: 2-way round-robin arbiter. Inputs are req[1:0] and the accept strobe; outputs are a one-hot grant and the winner index. It holds the pointer register.
- Top level: FSM, wait counter, request capture registers, pin output flops, DQ tristate enable flop, and read-data demux per master.

## Test plan
- m0 writes addr 18'h00010, data 16'hA55A, be=11 → SETUP at cycle 1, WE=0 in cycles 2–4, DQ=A55A in cycles 1–5, CE high in cycle 5.
- m1 reads 18'h00010 with a model returning A55A → OE=0 in cycles 2–4, m1_rsp_valid pulses in cycle 5, m1_rdata=16'hA55A; m0_rsp_valid stays 0.
- m0 and m1 both held valid for 8 accesses → grants alternate m0,m1,m0,… starting with m0 after reset; every access is 6 cycles long.
- m0 reads with be=2'b01 and the model returning 16'h1234 → LB=0, UB=1, m0_rdata=16'h0034.
- sys_rst asserted in the second WRITE cycle → next edge all strobes are 1, DQ high-Z, ready low; after release m0 is granted first.
- Sweep WR_CYC=1, RD_CYC=5, TURN_CYC=2 → WE low for exactly 1 cycle, OE low for 5 cycles, read response in cycle 7.
